// File: rtl/marv32_pkg.sv
// Shared marv32 definitions: controller state encoding, PC-select encoding
// and the width of the controller's internal down-counters.
package marv32_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_TRAP   = 2'b10,
    PC_MEPC   = 2'b11
  } pc_src_t;

  // A counter reading 0 or 1 is on its final cycle, so a zero load acts as one.
  function automatic logic cnt_last(input logic [CNT_W-1:0] c);
    return c <= CNT_W'(1);
  endfunction

endpackage

// File: rtl/marv32_down_counter.sv
// Loadable down-counter that saturates at zero; reset loads init_value.
module marv32_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] init_value,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= init_value;
    else if (load)
      count <= load_value;
    else if (dec && count != '0)
      count <= count - WIDTH'(1);
  end

endmodule

// File: rtl/marv32_pipeline_controller.sv
// marv32 pipeline hazard/redirect controller: reset hold, PC redirects with
// decode flush bubbles, memory-busy freeze and load-use stalls.
module marv32_pipeline_controller
  import marv32_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        branch_taken_in,
  input  logic        jump_in,
  input  logic        trap_req_in,
  input  logic        mret_in,
  input  logic        load_use_hazard_in,
  input  logic        mem_busy_in,
  output logic        flush_out,
  output logic        stall_pc_out,
  output logic        stall_if_id_out,
  output logic [1:0]  pc_src_out,
  output logic        trap_ack_out,
  output logic [31:0] redirect_count_out
);

  localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(RESET_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);

  state_t            state, state_next;
  logic [CNT_W-1:0]  hold_cnt, flush_cnt;
  logic              hold_dec, flush_load, flush_dec;
  logic              redirect;
  pc_src_t           redirect_sel;
  logic [31:0]       redirect_count;

  marv32_down_counter #(.WIDTH(CNT_W)) u_hold_cnt (
    .clk        (clk_in),
    .rst        (rst_in),
    .init_value (HOLD_INIT),
    .load       (1'b0),
    .load_value (HOLD_INIT),
    .dec        (hold_dec),
    .count      (hold_cnt)
  );

  marv32_down_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk        (clk_in),
    .rst        (rst_in),
    .init_value ('0),
    .load       (flush_load),
    .load_value (FLUSH_INIT),
    .dec        (flush_dec),
    .count      (flush_cnt)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= HOLD;
      redirect_count <= '0;
    end else begin
      state <= state_next;
      if (redirect)
        redirect_count <= redirect_count + 32'd1;
    end
  end

  assign redirect_count_out = redirect_count;

  assign redirect = (state != HOLD) && !mem_busy_in &&
                    (trap_req_in || mret_in || branch_taken_in || jump_in);

  always_comb begin
    redirect_sel = PC_TARGET;
    if (trap_req_in)
      redirect_sel = PC_TRAP;
    else if (mret_in)
      redirect_sel = PC_MEPC;
  end

  always_comb begin
    state_next      = state;
    flush_out       = 1'b0;
    stall_pc_out    = 1'b0;
    stall_if_id_out = 1'b0;
    pc_src_out      = PC_PLUS4;
    trap_ack_out    = 1'b0;
    hold_dec        = 1'b0;
    flush_load      = 1'b0;
    flush_dec       = 1'b0;

    unique case (state)
      HOLD: begin
        flush_out       = 1'b1;
        stall_pc_out    = 1'b1;
        stall_if_id_out = 1'b1;
        hold_dec        = 1'b1;
        if (cnt_last(hold_cnt))
          state_next = RUN;
      end
      RUN: begin
        if (mem_busy_in) begin
          stall_pc_out    = 1'b1;
          stall_if_id_out = 1'b1;
          state_next      = STALL;
        end else if (load_use_hazard_in) begin
          stall_pc_out    = 1'b1;
          stall_if_id_out = 1'b1;
        end
      end
      STALL: begin
        stall_pc_out    = 1'b1;
        stall_if_id_out = 1'b1;
        if (!mem_busy_in)
          state_next = RUN;
      end
      FLUSH: begin
        flush_out = 1'b1;
        if (mem_busy_in) begin
          stall_pc_out    = 1'b1;
          stall_if_id_out = 1'b1;
        end else begin
          flush_dec = 1'b1;
          if (cnt_last(flush_cnt))
            state_next = RUN;
        end
      end
      default: state_next = HOLD;
    endcase

    // An accepted redirect must let the PC load its new source, so it
    // overrides any stall request computed above.
    if (redirect) begin
      pc_src_out      = redirect_sel;
      trap_ack_out    = trap_req_in;
      stall_pc_out    = 1'b0;
      stall_if_id_out = 1'b0;
      flush_load      = 1'b1;
      state_next      = FLUSH;
    end
  end

endmodule

// File: tb/tb_marv32_pipeline_controller.sv
// Scoreboard bench for marv32_pipeline_controller: the driver queues the
// expected per-cycle outputs, the monitor pops and compares each cycle.
module tb_marv32_pipeline_controller;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        branch_taken_in = 1'b0;
  logic        jump_in = 1'b0;
  logic        trap_req_in = 1'b0;
  logic        mret_in = 1'b0;
  logic        load_use_hazard_in = 1'b0;
  logic        mem_busy_in = 1'b0;
  logic        flush_out;
  logic        stall_pc_out;
  logic        stall_if_id_out;
  logic [1:0]  pc_src_out;
  logic        trap_ack_out;
  logic [31:0] redirect_count_out;

  marv32_pipeline_controller #(
    .RESET_HOLD_CYCLES (2),
    .FLUSH_CYCLES      (1)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .branch_taken_in    (branch_taken_in),
    .jump_in            (jump_in),
    .trap_req_in        (trap_req_in),
    .mret_in            (mret_in),
    .load_use_hazard_in (load_use_hazard_in),
    .mem_busy_in        (mem_busy_in),
    .flush_out          (flush_out),
    .stall_pc_out       (stall_pc_out),
    .stall_if_id_out    (stall_if_id_out),
    .pc_src_out         (pc_src_out),
    .trap_ack_out       (trap_ack_out),
    .redirect_count_out (redirect_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Input vector bits: {rst, trap, mret, branch, jump, load_use, mem_busy}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_RST  = 7'b1000000;
  localparam logic [6:0] I_TRAP = 7'b0100000;
  localparam logic [6:0] I_MRET = 7'b0010000;
  localparam logic [6:0] I_BR   = 7'b0001000;
  localparam logic [6:0] I_JMP  = 7'b0000100;
  localparam logic [6:0] I_LU   = 7'b0000010;
  localparam logic [6:0] I_MB   = 7'b0000001;

  // Output vector bits: {flush, stall_pc, stall_if_id, pc_src[1:0], trap_ack}
  localparam logic [5:0] O_HOLD  = 6'b111_00_0;
  localparam logic [5:0] O_RUN   = 6'b000_00_0;
  localparam logic [5:0] O_FLUSH = 6'b100_00_0;
  localparam logic [5:0] O_FLSTL = 6'b111_00_0;
  localparam logic [5:0] O_STALL = 6'b011_00_0;
  localparam logic [5:0] O_BR    = 6'b000_01_0;
  localparam logic [5:0] O_FLBR  = 6'b100_01_0;
  localparam logic [5:0] O_TRAP  = 6'b000_10_1;
  localparam logic [5:0] O_MRET  = 6'b000_11_0;

  typedef struct {
    logic [5:0]  outs;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic drive(input logic [6:0] v);
    rst_in             = v[6];
    trap_req_in        = v[5];
    mret_in            = v[4];
    branch_taken_in    = v[3];
    jump_in            = v[2];
    load_use_hazard_in = v[1];
    mem_busy_in        = v[0];
  endtask

  task automatic step(input logic [6:0] v, input logic [5:0] eo,
                      input logic [31:0] ec, input string name);
    exp_t e;
    @(posedge clk_in);
    #1;
    drive(v);
    e.outs = eo;
    e.cnt  = ec;
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: the controller presents a response every cycle.
  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [37:0] act, req;
      e   = q.pop_front();
      act = {flush_out, stall_pc_out, stall_if_id_out, pc_src_out,
             trap_ack_out, redirect_count_out};
      req = {e.outs, e.cnt};
      total++;
      if (act === req)
        passed++;
      else
        $display("FAIL %s: got outs=%b cnt=%h, expected outs=%b cnt=%h",
                 e.name, act[37:32], act[31:0], req[37:32], req[31:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held three cycles, then hold window of two cycles
    step(I_RST,  O_HOLD,  32'd0, "reset_1");
    step(I_RST,  O_HOLD,  32'd0, "reset_2");
    step(I_RST,  O_HOLD,  32'd0, "reset_3");
    step(I_NONE, O_HOLD,  32'd0, "hold_1");
    step(I_TRAP, O_HOLD,  32'd0, "hold_2_trap_ignored");
    step(I_NONE, O_RUN,   32'd0, "run_idle");
    // branch
    step(I_BR,   O_BR,    32'd0, "branch_select");
    step(I_NONE, O_FLUSH, 32'd1, "branch_flush");
    step(I_NONE, O_RUN,   32'd1, "branch_back_run");
    // simultaneous trap/mret/jump: trap wins
    step(I_TRAP | I_MRET | I_JMP, O_TRAP, 32'd1, "simul_trap");
    step(I_NONE, O_FLUSH, 32'd2, "simul_flush");
    step(I_NONE, O_RUN,   32'd2, "simul_back_run");
    // mret
    step(I_MRET, O_MRET,  32'd2, "mret_select");
    step(I_NONE, O_FLUSH, 32'd3, "mret_flush");
    step(I_NONE, O_RUN,   32'd3, "mret_back_run");
    // jump then memory busy for three cycles during flush
    step(I_JMP,  O_BR,    32'd3, "jump_select");
    step(I_MB,   O_FLSTL, 32'd4, "flush_busy_1");
    step(I_MB,   O_FLSTL, 32'd4, "flush_busy_2");
    step(I_MB,   O_FLSTL, 32'd4, "flush_busy_3");
    step(I_NONE, O_FLUSH, 32'd4, "flush_resume");
    step(I_NONE, O_RUN,   32'd4, "flush_done_run");
    // branch under mem_busy is not accepted; trap in STALL under busy not acked
    step(I_BR | I_MB,   O_STALL, 32'd4, "busy_branch_blocked");
    step(I_TRAP | I_MB, O_STALL, 32'd4, "stall_trap_blocked");
    step(I_NONE, O_STALL, 32'd4, "stall_release");
    step(I_NONE, O_RUN,   32'd4, "stall_back_run");
    // load-use hazard two cycles
    step(I_LU,   O_STALL, 32'd4, "load_use_1");
    step(I_LU,   O_STALL, 32'd4, "load_use_2");
    step(I_NONE, O_RUN,   32'd4, "load_use_no_state_change");
    // redirect beats load-use; redirect during FLUSH reloads
    step(I_LU | I_BR, O_BR,   32'd4, "load_use_branch_wins");
    step(I_JMP,  O_FLBR,  32'd5, "flush_redirect");
    step(I_NONE, O_FLUSH, 32'd6, "flush_reloaded");
    step(I_NONE, O_RUN,   32'd6, "reload_back_run");
    // reset mid-flush
    step(I_BR,   O_BR,    32'd6, "pre_reset_branch");
    step(I_RST,  O_FLUSH, 32'd7, "reset_in_flush");
    step(I_NONE, O_HOLD,  32'd0, "hold_after_reset_1");
    step(I_NONE, O_HOLD,  32'd0, "hold_after_reset_2");
    step(I_NONE, O_RUN,   32'd0, "run_after_reset");
    // redirect counter wrap
    begin
      exp_t e;
      @(posedge clk_in);
      #1;
      force dut.redirect_count = 32'hFFFF_FFFF;
      release dut.redirect_count;
      drive(I_NONE);
      e.outs = O_RUN;
      e.cnt  = 32'hFFFF_FFFF;
      e.name = "count_preset";
      q.push_back(e);
    end
    step(I_BR,   O_BR,    32'hFFFF_FFFF, "wrap_branch");
    step(I_NONE, O_FLUSH, 32'd0, "wrap_to_zero");
    step(I_NONE, O_RUN,   32'd0, "wrap_back_run");

    @(negedge clk_in);
    @(negedge clk_in);
    total++;
    if (q.size() == 0)
      passed++;
    else
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
